mem_arbiter: RTL and testbench

//  Shares one single-ported, fixed-latency memory between instruction fetch (IF)
//  and the data-memory stage (DM). Grants one requester, issues the access and

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, fixed-latency memory between
// instruction fetch (IF) and the data-memory stage (DM), and sequences the
// halt-time memory dump.
//
// Parameters:
//   LATENCY        cycles from issue to valid mem_rdata (1..15)
// Optional build macro:
//   MEM_ARB_RR_EN  round-robin arbitration between IF and DM when both pend;
//                  undefined gives fixed DM-over-IF priority.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           IF read request (held until if_done) and address
//   if_rdata/if_done         IF read data (held) and one-cycle completion pulse
//   if_stall                 if_req & ~if_done
//   dm_req/dm_wr/dm_addr     DM request (held until dm_done), write flag, address
//   dm_wdata                 DM write data
//   dm_rdata/dm_done         DM read data (unchanged by writes), completion pulse
//   dm_stall                 dm_req & ~dm_done
//   halt                     processor halt level
//   mem_enable/mem_wr        memory strobe and write flag, issue cycle only
//   mem_addr/mem_wdata       memory address / write data, zero outside issue
//   mem_rdata                memory read data, valid LATENCY cycles after issue
//   mem_createdump           one-cycle dump strobe on entering HALTED
//
// state   | meaning
// IDLE    | no access in flight; grants and halt are evaluated here
// BUSY_IF | IF access in flight, counting latency
// BUSY_DM | DM access in flight, counting latency
// HALTED  | dump issued; no further grants until reset
module mem_arbiter #(
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    input  logic        halt,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_createdump
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, HALTED} state_t;

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    state_t     state;
    logic [3:0] cnt;
    logic       dm_wr_q;
    logic       grant_if;
    logic       grant_dm;

`ifdef MEM_ARB_RR_EN
    logic last_grant_dm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_dm <= 1'b0;
        end else if (grant_if || grant_dm) begin
            last_grant_dm <= grant_dm;
        end
    end
`endif

    // Grant is combinational so the memory sees the access in the issue cycle.
    // Gating with rst keeps mem_* quiet while reset is held.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (!rst && state == IDLE && !halt) begin
`ifdef MEM_ARB_RR_EN
            if (if_req && dm_req) begin
                grant_dm = ~last_grant_dm;
                grant_if = last_grant_dm;
            end else begin
                grant_dm = dm_req;
                grant_if = if_req;
            end
`else
            grant_dm = dm_req;
            grant_if = if_req & ~dm_req;
`endif
        end
    end

    assign mem_enable = grant_if | grant_dm;
    assign mem_wr     = grant_dm & dm_wr;
    assign mem_addr   = grant_dm ? dm_addr : (grant_if ? if_addr : 16'h0000);
    assign mem_wdata  = (grant_dm && dm_wr) ? dm_wdata : 16'h0000;

    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            dm_wr_q        <= 1'b0;
            if_rdata       <= 16'h0000;
            dm_rdata       <= 16'h0000;
            if_done        <= 1'b0;
            dm_done        <= 1'b0;
            mem_createdump <= 1'b0;
        end else begin
            if_done        <= 1'b0;
            dm_done        <= 1'b0;
            mem_createdump <= 1'b0;
            case (state)
                IDLE: begin
                    if (halt) begin
                        state          <= HALTED;
                        mem_createdump <= 1'b1;
                    end else if (grant_dm) begin
                        state   <= BUSY_DM;
                        cnt     <= LAT_CNT;
                        dm_wr_q <= dm_wr;
                    end else if (grant_if) begin
                        state <= BUSY_IF;
                        cnt   <= LAT_CNT;
                    end
                end
                BUSY_IF: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        if_rdata <= mem_rdata;
                        if_done  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                BUSY_DM: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        // writes complete with a done pulse but leave dm_rdata alone
                        if (!dm_wr_q) begin
                            dm_rdata <= mem_rdata;
                        end
                        dm_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        halt;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_createdump;

    mem_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
        .halt(halt),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_createdump(mem_createdump)
    );

    typedef struct {
        int          due;
        logic [15:0] rd;
    } sb_t;

    sb_t sb_if[$];
    sb_t sb_dm[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] mem_model [0:255];
    logic [15:0] ret_data;
    int          ret_cyc = -1;
    logic        prev_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        chk(tag, {16'b0, obs}, {16'b0, exp});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input bit is_dm, input int due, input logic [15:0] rd);
        sb_t e;
        e.due = due;
        e.rd  = rd;
        if (is_dm) sb_dm.push_back(e);
        else       sb_if.push_back(e);
    endtask

    // Memory model: the write lands at issue, read data is presented only in
    // cycle issue+LAT; every other cycle carries a junk value.
    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 16'h0000;
        mem_model[8'h10] = 16'hBEEF;
        mem_rdata = 16'h0BAD;
        forever begin
            @(negedge clk);
            mem_rdata = (cyc == ret_cyc) ? ret_data : 16'h0BAD;
            if (mem_enable) begin
                if (mem_wr) mem_model[mem_addr[7:0]] = mem_wdata;
                else        ret_data = mem_model[mem_addr[7:0]];
                ret_cyc = cyc + LAT;
            end
        end
    end

    // Scoreboard: compare each done pulse with the entry pushed at issue.
    always @(negedge clk) begin
        sb_t e;
        if (!rst) begin
            if (prev_en) chk1("issue_spacing", mem_enable, 1'b0);
            prev_en = mem_enable;
            if (if_done) begin
                if (sb_if.size() == 0) begin
                    chk1("if_done_unexpected", if_done, 1'b0);
                end else begin
                    e = sb_if.pop_front();
                    chk("if_done_cycle", 32'(cyc), 32'(e.due));
                    chk16("if_rdata", if_rdata, e.rd);
                    chk1("if_stall_at_done", if_stall, 1'b0);
                end
            end
            if (dm_done) begin
                if (sb_dm.size() == 0) begin
                    chk1("dm_done_unexpected", dm_done, 1'b0);
                end else begin
                    e = sb_dm.pop_front();
                    chk("dm_done_cycle", 32'(cyc), 32'(e.due));
                    chk16("dm_rdata", dm_rdata, e.rd);
                    chk1("dm_stall_at_done", dm_stall, 1'b0);
                end
            end
        end else begin
            prev_en = 1'b0;
        end
    end

    // Starts an access at posedge+1 of the issue cycle and returns at
    // posedge+1 of the done cycle with the request still raised.
    task automatic access(input bit is_dm, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rd,
                          input string tag);
        if (is_dm) begin
            dm_req = 1'b1; dm_wr = wr; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        sb_push(is_dm, cyc + LAT + 1, exp_rd);
        @(negedge clk);
        chk1({tag, "_en"}, mem_enable, 1'b1);
        chk16({tag, "_addr"}, mem_addr, addr);
        chk1({tag, "_wr"}, mem_wr, is_dm & wr);
        chk16({tag, "_wdata"}, mem_wdata, (is_dm && wr) ? wdata : 16'h0000);
        for (int k = 1; k <= LAT; k++) begin
            next_cycle();
            if (k == 1) begin
                if (is_dm) begin
                    dm_addr = ~addr; dm_wdata = ~wdata; dm_wr = ~wr;
                end else begin
                    if_addr = ~addr;
                end
            end
            @(negedge clk);
            chk1({tag, "_en_busy"}, mem_enable, 1'b0);
            chk16({tag, "_addr_busy"}, mem_addr, 16'h0000);
            chk1({tag, "_stall_busy"}, is_dm ? dm_stall : if_stall, 1'b1);
        end
        next_cycle();
    endtask

    initial begin
        logic exp_dm;
        rst = 1'b1; if_req = 1'b0; if_addr = 16'h0; dm_req = 1'b0; dm_wr = 1'b0;
        dm_addr = 16'h0; dm_wdata = 16'h0; halt = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("init_rdata", {if_rdata, dm_rdata}, 32'h0);
        chk("init_strobes", {25'b0, if_done, dm_done, if_stall, dm_stall,
                             mem_enable, mem_wr, mem_createdump}, 32'h0);
        next_cycle();

        // IF read
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, "if_rd");
        if_req = 1'b0;
        @(negedge clk);
        chk1("if_rd_no_reissue", mem_enable, 1'b0);
        next_cycle();

        // DM write then read, second issue in the write's done cycle
        access(1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000, "dm_wr");
        access(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, "dm_rd");
        dm_req = 1'b0;
        @(negedge clk);
        chk1("dm_rd_no_reissue", mem_enable, 1'b0);
        next_cycle();

        // Contention, DM keeps re-requesting
        if_req = 1'b1; if_addr = 16'h0010;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
        for (int g = 0; g < 3; g++) begin
`ifdef MEM_ARB_RR_EN
            exp_dm = (g != 1);
`else
            exp_dm = 1'b1;
`endif
            sb_push(exp_dm, cyc + LAT + 1, exp_dm ? 16'h1234 : 16'hBEEF);
            @(negedge clk);
            chk1("cont_en", mem_enable, 1'b1);
            chk16("cont_grant_addr", mem_addr, exp_dm ? 16'h0020 : 16'h0010);
            repeat (LAT) begin
                next_cycle();
                @(negedge clk);
                chk1("cont_en_busy", mem_enable, 1'b0);
                chk("cont_stalls", {30'b0, if_stall, dm_stall}, 32'h3);
            end
            next_cycle();
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        chk1("cont_idle", mem_enable, 1'b0);
        next_cycle();

        // Async reset mid-cycle clears everything without a clock edge
        if_req = 1'b1; if_addr = 16'h0010;
        @(negedge clk);
        chk1("pre_rst_en", mem_enable, 1'b1);
        chk("pre_rst_rdata", {if_rdata, dm_rdata}, {16'hBEEF, 16'h1234});
        #2;
        rst = 1'b1; if_req = 1'b0;
        #1;
        chk("rst_rdata", {if_rdata, dm_rdata}, 32'h0);
        chk("rst_strobes", {25'b0, if_done, dm_done, if_stall, dm_stall,
                            mem_enable, mem_wr, mem_createdump}, 32'h0);
        chk("rst_bus", {mem_addr, mem_wdata}, 32'h0);
        sb_if.delete();
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Reset during a DM read abandons it
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
        @(negedge clk);
        chk1("abort_issue", mem_enable, 1'b1);
        repeat (2) next_cycle();
        rst = 1'b1;
        #1;
        chk1("abort_en_in_rst", mem_enable, 1'b0);
        next_cycle();
        rst = 1'b0; dm_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk1("abort_no_dm_done", dm_done, 1'b0);
            chk16("abort_dm_rdata", dm_rdata, 16'h0000);
            next_cycle();
        end
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, "if_after_rst");
        if_req = 1'b0;
        next_cycle();

        // Halt while IF is busy: completion, then a single dump
        if_req = 1'b1; if_addr = 16'h0010;
        sb_push(1'b0, cyc + LAT + 1, 16'hBEEF);
        @(negedge clk);
        chk1("halt_issue", mem_enable, 1'b1);
        for (int k = 1; k <= LAT; k++) begin
            next_cycle();
            if (k == 1) halt = 1'b1;
            if (k == LAT) begin
                dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
            end
            @(negedge clk);
            chk1("halt_busy_en", mem_enable, 1'b0);
            chk1("halt_busy_dump", mem_createdump, 1'b0);
        end
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        chk1("halt_done_cycle_en", mem_enable, 1'b0);
        chk1("halt_done_cycle_dump", mem_createdump, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("halt_dump", mem_createdump, 1'b1);
        chk1("halt_dump_en", mem_enable, 1'b0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if (k == 0) halt = 1'b0;
            if (k == 2) if_req = 1'b1;
            @(negedge clk);
            chk1("halted_dump", mem_createdump, 1'b0);
            chk1("halted_en", mem_enable, 1'b0);
            chk1("halted_dm_stall", dm_stall, 1'b1);
        end
        if_req = 1'b0; dm_req = 1'b0;
        next_cycle();

        chk("sb_if_drained", 32'(sb_if.size()), 32'h0);
        chk("sb_dm_drained", 32'(sb_dm.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
